// File: rtl/booth_mul_seq_ctrl.sv
// Iterative radix-4 Booth multiplier sequencer: two partial products per cycle through one 4-2 compressor row, then one carry-propagate add.
// Latency N_CYC+2 edges from accept; DONE holds result until out_ready. Optional MUL_EARLY_TERM_EN stops compressing once the remaining Booth digits are zero.
module booth_mul_seq_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int N_PP  = (XLEN + 2) / 2;
    localparam int N_CYC = (N_PP + 1) / 2;
    localparam int W     = 2 * XLEN;
    localparam int EW    = XLEN + 2;
    localparam int CW    = $clog2(N_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_COMPRESS, S_ADD, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [EW-1:0]   x_q, x_d, y_q, y_d;
    logic [W-1:0]    sum_q, sum_d, carry_q, carry_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    logic [EW:0]     yext;
    logic [W-1:0]    pp_a, pp_b, s1, c1, ei, row_s, row_co;
    logic            last_iter;
    logic            rs1_sgn, rs2_sgn;

    // Digit k multiplies X by {-2..2} and is weighted by 4^k; digits past the last are zero.
    function automatic logic [W-1:0] booth_pp(input logic [EW:0] ye, input logic [EW-1:0] x,
                                              input int k);
        logic [W-1:0] xe;
        logic [W-1:0] pp;
        logic [2:0]   trip;
        pp = '0;
        if (k < N_PP) begin
            trip = ye[2*k +: 3];
            xe   = {{(W-EW){x[EW-1]}}, x};
            case (trip)
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe << 1;
                3'b100:         pp = -(xe << 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            pp = pp << (2 * k);
        end
        return pp;
    endfunction

    assign yext = {y_q, 1'b0};

    always_comb begin
        pp_a   = booth_pp(yext, x_q, 2 * int'(cnt_q));
        pp_b   = booth_pp(yext, x_q, 2 * int'(cnt_q) + 1);
        // 4-2 row: first full adder level feeds its carry into the neighbour's second level.
        s1     = sum_q ^ carry_q ^ pp_a;
        c1     = (sum_q & carry_q) | (sum_q & pp_a) | (carry_q & pp_a);
        ei     = {c1[W-2:0], 1'b0};
        row_s  = s1 ^ pp_b ^ ei;
        row_co = (s1 & pp_b) | (s1 & ei) | (pp_b & ei);
    end

    always_comb begin
        last_iter = (cnt_q == CW'(N_CYC - 1));
`ifdef MUL_EARLY_TERM_EN
        begin
            logic rest_zero;
            rest_zero = 1'b1;
            for (int k = 0; k < N_PP; k++) begin
                if (k >= 2 * (int'(cnt_q) + 1) && yext[2*k +: 3] != 3'b000 && yext[2*k +: 3] != 3'b111)
                    rest_zero = 1'b0;
            end
            last_iter = last_iter || rest_zero;
        end
`endif
    end

    assign rs1_sgn = (op != 2'b11);
    assign rs2_sgn = ~op[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = op;
                    x_d     = {{2{rs1[XLEN-1] & rs1_sgn}}, rs1};
                    y_d     = {{2{rs2[XLEN-1] & rs2_sgn}}, rs2};
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = S_COMPRESS;
                end
            end
            S_COMPRESS: begin
                sum_d   = row_s;
                carry_d = {row_co[W-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (last_iter)
                    state_d = S_ADD;
            end
            S_ADD: begin
                sum_d   = sum_q + carry_q;
                state_d = S_DONE;
            end
            default: begin
                // First DONE cycle publishes the result; afterwards wait for the consumer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    result_d    = (op_q == 2'b00) ? sum_q[XLEN-1:0] : sum_q[W-1:XLEN];
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
        endcase
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_booth_mul_seq_ctrl.sv
// Directed bench for booth_mul_seq_ctrl (XLEN=64) plus a short random sweep against a 128-bit reference multiply.
module tb_booth_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [63:0] rs1, rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mul_seq_ctrl #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs1(rs1), .rs2(rs2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ae, be, p;
        ae = {{64{a[63] & (o != 2'b11)}}, a};
        be = {{64{b[63] & ~o[1]}}, b};
        p  = ae * be;
        return (o == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    // Issue one op with out_ready high; lat = edges from accept to out_valid (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = ~o; rs1 = ~a; rs2 = ~b;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
        end
        lat = out_valid ? n : -1;
        res = result;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] r, r0;
        logic [1:0]  o;
        logic [63:0] a, b;
        int          lat, n;
        logic        seen, stable;

        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_op(2'b00, 64'd3, 64'd5, r, lat);
        check("mul_3x5", r, 64'd15);
`ifndef MUL_EARLY_TERM_EN
        check("mul_3x5_latency", 64'(lat), 64'd19);
`endif
        run_op(2'b00, '1, '1, r, lat);
        check("mul_m1xm1", r, 64'd1);
        run_op(2'b01, '1, '1, r, lat);
        check("mulh_m1xm1", r, 64'd0);
        run_op(2'b11, '1, '1, r, lat);
        check("mulhu_max", r, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(2'b10, '1, 64'd2, r, lat);
        check("mulhsu_m1x2", r, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r, lat);
        check("mulh_min_sq", r, 64'h4000_0000_0000_0000);

        // Flush partway through COMPRESS: nothing may come out.
        @(negedge clk);
        op = 2'b00; rs1 = 64'd100; rs2 = 64'd100; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        run_op(2'b00, 64'd7, 64'd6, r, lat);
        check("mul_7x6_after_flush", r, 64'd42);

        // flush together with in_valid in IDLE blocks the accept.
        @(negedge clk);
        op = 2'b00; rs1 = 64'd1; rs2 = 64'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", 64'(busy), 64'd0);
        check("idle_flush_in_ready", 64'(in_ready), 64'd1);

        // Back-pressure in DONE.
        @(negedge clk);
        op = 2'b00; rs1 = 64'd123; rs2 = 64'd1000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_rise", 64'(out_valid), 64'd1);
        r0 = result;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || result !== r0 || in_ready) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_result", result, 64'd123000);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_drain_out_valid", 64'(out_valid), 64'd0);
        check("bp_drain_in_ready", 64'(in_ready), 64'd1);

        // Reset during COMPRESS discards the op.
        @(negedge clk);
        op = 2'b00; rs1 = 64'd11; rs2 = 64'd13; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);

        run_op(2'b00, 64'd9, 64'd3, r, lat);
        check("mul_9x3", r, 64'd27);
`ifdef MUL_EARLY_TERM_EN
        check("mul_9x3_latency", 64'(lat), 64'd3);
`else
        check("mul_9x3_latency", 64'(lat), 64'd19);
`endif

        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 7 == 1) a = 64'h8000_0000_0000_0000;
            if (i % 5 == 2) b = 64'(signed'($urandom_range(0, 40)) - 20);
            run_op(o, a, b, r, lat);
            check("rnd_completed", 64'(lat > 0), 64'd1);
            check("rnd_result", r, model(o, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
